tally_accum: RTL

TALLY_ACCUM -- requirements
Module: tally_accum

---
 rtl/tally_accum_pkg.sv | 14 +
 rtl/onehot_dec5.sv | 24 ++
 rtl/tally_accum.sv | 94 +++++++++
 3 files changed

// File: rtl/tally_accum_pkg.sv
// Shared definitions for the tally accumulator: FSM states, default window
// width and the width of the one-hot count bus.
package tally_accum_pkg;

  localparam int WIN_W_DEF = 4;
  localparam int ONEHOT_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/onehot_dec5.sv
// Converts a 5-bit one-hot ones-count into its binary value (0..4).
// Any pattern that is not exactly one set bit yields 0 and raises illegal.
module onehot_dec5
  import tally_accum_pkg::*;
(
  input  logic [ONEHOT_W-1:0] onehot,
  output logic [2:0]          value,
  output logic                illegal
);

  always_comb begin
    value   = 3'd0;
    illegal = 1'b0;
    case (onehot)
      5'b00001: value = 3'd0;
      5'b00010: value = 3'd1;
      5'b00100: value = 3'd2;
      5'b01000: value = 3'd3;
      5'b10000: value = 3'd4;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/tally_accum.sv
// Sums decoded one-hot counts over a programmable window of samples and
// holds the result with a valid/ack handshake.
module tally_accum
  import tally_accum_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF,
  parameter int SUM_W = WIN_W + 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ena,
  input  logic                start,
  input  logic [WIN_W-1:0]    win_len,
  input  logic                in_valid,
  input  logic [ONEHOT_W-1:0] onehot,
  output logic [SUM_W-1:0]    sum,
  output logic                sum_valid,
  input  logic                sum_ack,
  output logic                busy,
  output logic                err
);

  // One extra bit so the counter and latched length can represent 2^WIN_W.
  localparam int CNT_W = WIN_W + 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, len_q, len_eff, cnt_inc;
  logic [2:0]       value;
  logic             illegal;
  logic             accept, last;
  logic             busy_nxt, valid_nxt;

  onehot_dec5 u_dec (
    .onehot  (onehot),
    .value   (value),
    .illegal (illegal)
  );

  assign len_eff = (win_len == '0) ? (CNT_W'(1) << WIN_W) : {1'b0, win_len};
  assign accept  = ena && in_valid && (state == ACCUM);
  assign cnt_inc = cnt + CNT_W'(1);
  assign last    = accept && (cnt_inc == len_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      sum_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= busy_nxt;
      sum_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (ena) begin
      case (state)
        IDLE:    if (start)   state_nxt = ACCUM;
        ACCUM:   if (last)    state_nxt = DONE;
        DONE:    if (sum_ack) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Flags are computed from the next state so they land in flops alongside it.
  always_comb begin
    busy_nxt  = (state_nxt != IDLE);
    valid_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum   <= '0;
      err   <= 1'b0;
      cnt   <= '0;
      len_q <= '0;
    end else if (ena) begin
      if (state == IDLE && start) begin
        len_q <= len_eff;
        sum   <= '0;
        err   <= 1'b0;
        cnt   <= '0;
      end else if (accept) begin
        sum <= sum + SUM_W'(value);
        err <= err | illegal;
        cnt <= cnt_inc;
      end
    end
  end

endmodule
